spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- SPI Mode 0 master that drives the SPI slave port of the design: 8-bit, MSb-first, full-duplex transfers.
- Runs entirely on sysClk_i. Generates SClk with a programmable divider, asserts /SS for the whole byte, shifts MOSI out and samples MISO in.
- A simple start/ready/done handshake lets the CPU or a test sequencer issue back-to-back bytes.

Parameters:
- CLK_DIV, 4, SClk half-period in sysClk_i cycles. Legal range is 4..255; an elaboration-time check rejects smaller values because the slave's 2-FF CDC needs the slack.
- GAP_CYCLES, 4, minimum number of sysClk_i cycles ss_o_n stays high between transfers.

Ports:
- sysClk_i  in  1  system clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request a transfer; accepted only in the cycle where ready_o=1.
- byte_to_send_i  in  8  byte to transmit; captured in the accept cycle.
- ready_o  out  1  idle and able to accept start_i.
- done_o  out  1  one-cycle pulse when byte_received_o is valid.
- byte_received_o  out  8  last received byte; holds until the next done_o.
- sclk_o  out  1  SPI clock; idle level is low (CPOL=0).
- mosi_o  out  1  master-out data.
- miso_i  in  1  master-in data; asynchronous to sysClk_i.
- ss_o_n  out  1  slave select, active low.

Behaviour:
- Reset (sync, reset_i=1 at a sysClk_i edge), applied regardless of the current state:
  - ss_o_n=1, sclk_o=0, mosi_o=0, ready_o=1, done_o=0, byte_received_o=8'h00.
  - FSM goes to IDLE; all counters and shift registers are cleared.
  - A transfer in progress is aborted silently, with no done_o.
- MISO passes through a 2-FF synchronizer (miso_s). miso_s is also reset to 0.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - ready_o=1.
  - If start_i=1, latch tx_sr<=byte_to_send_i and go to SETUP.
  - From the next cycle: ss_o_n=0, mosi_o=byte_to_send_i[7], ready_o=0.
- SETUP:
  - sclk_o stays 0 for CLK_DIV cycles, giving MOSI setup time before the first rising edge. Then go to SHIFT.
- SHIFT: 16 half-periods of CLK_DIV cycles each, with a half-period counter and a 4-bit edge counter.
  - Each half-period end toggles sclk_o.
  - Rising edge (sclk_o 0->1): rx_sr<={rx_sr[6:0], miso_s}.
  - Falling edge (1->0): tx_sr<={tx_sr[6:0],1'b0} and mosi_o<=next bit.
    - On the 8th falling edge, mosi_o<=0 and the FSM goes to HOLD.
  - Exactly 8 rising and 8 falling edges occur per transfer; sclk_o ends low.
- HOLD:
  - CLK_DIV cycles with sclk_o=0 and ss_o_n=0.
  - On exit: ss_o_n<=1, byte_received_o<=rx_sr, done_o=1 for one cycle. Then go to GAP.
- GAP:
  - ss_o_n=1 for GAP_CYCLES cycles, so the slave's synchronized /SS sees a deassert. Then go to IDLE (ready_o=1).
- Timing:
  - ss_o_n is low for exactly 18*CLK_DIV cycles.
  - done_o fires 18*CLK_DIV+1 cycles after the accept cycle.
  - Start-to-start minimum is 18*CLK_DIV+GAP_CYCLES+1 cycles.
- start_i while ready_o=0 is ignored and not queued. byte_to_send_i changes after the accept cycle have no effect.
- done_o and ready_o are never high in the same cycle.
- byte_received_o changes only on the done_o cycle.
- The received MSb is the MISO value synchronized at the first rising edge. The 2-cycle synchronizer latency is acceptable because CLK_DIV>=4 and the slave drives MISO from its previous edge.

Test Plan:
- Reset mid-transfer: start 8'hA5, assert reset_i at SHIFT edge 5 -> next cycle ss_o_n=1, sclk_o=0, ready_o=1, no done_o, byte_received_o=8'h00.
- Loopback (miso_i tied to mosi_o), CLK_DIV=4: send 8'hA5 ->
  - mosi_o at the 8 rising edges = 1,0,1,0,0,1,0,1;
  - ss_o_n low 72 cycles; done_o at cycle 73; byte_received_o=8'hA5.
- Pair with the SPI slave block (slave byte_to_send_i=8'h3C), master sends 8'hC3 -> master byte_received_o=8'h3C, slave byte_received_o=8'hC3.
- Back-to-back: hold start_i=1 with 8'h01 then 8'hFF -> two transfers, ss_o_n high ≥4 cycles between them, start-to-start 77 cycles, exactly two done_o pulses.
- start_i pulsed while busy (cycle 10 of a transfer) -> ignored; only one done_o; the transfer is unchanged.
- Edge/level check, CLK_DIV=6: 8 rising and 8 falling sclk_o edges per transfer, each high/low phase 6 cycles, and sclk_o=0 whenever ss_o_n=1.

Source files
------------

// File: rtl/spi_master_if.sv
// Byte handshake and SPI pin bundle for spi_master.
// The master modport is the DUT side; slave is the sequencer/pin side.
interface spi_master_if;
    logic       start_i;
    logic [7:0] byte_to_send_i;
    logic       ready_o;
    logic       done_o;
    logic [7:0] byte_received_o;
    logic       sclk_o;
    logic       mosi_o;
    logic       miso_i;
    logic       ss_o_n;

    modport master (
        input  start_i, byte_to_send_i, miso_i,
        output ready_o, done_o, byte_received_o, sclk_o, mosi_o, ss_o_n
    );

    modport slave (
        output start_i, byte_to_send_i, miso_i,
        input  ready_o, done_o, byte_received_o, sclk_o, mosi_o, ss_o_n
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode 0 master: 8-bit MSb-first full-duplex transfers on a single system clock,
// SClk from a half-period divider, start/ready/done byte handshake.
module spi_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic          sysClk_i,
    input  logic          reset_i,
    spi_master_if.master  bus
);

    generate
        if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_div
            $error("spi_master: CLK_DIV must be in 4..255");
        end
        if (GAP_CYCLES < 1 || GAP_CYCLES > 256) begin : g_bad_gap
            $error("spi_master: GAP_CYCLES must be in 1..256");
        end
    endgenerate

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t     state;
    state_t     state_d;

    logic [7:0] cnt;
    logic [3:0] edge_cnt;
    logic       div_tick;
    logic       gap_tick;

    // Bits still to send; the current MSb already sits on mosi_q.
    logic [6:0] tx_sr;
    logic [7:0] rx_sr;
    logic       miso_meta;
    logic       miso_s;

    logic       sclk_q;
    logic       mosi_q;
    logic       ss_n_q;
    logic       done_q;
    logic [7:0] rx_byte_q;
    logic       ready;

    assign div_tick = (cnt == DIV_LAST);
    assign gap_tick = (cnt == GAP_LAST);

    always_ff @(posedge sysClk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.start_i) state_d = SETUP;
            SETUP:   if (div_tick) state_d = SHIFT;
            SHIFT:   if (div_tick && sclk_q && edge_cnt == 4'd15) state_d = HOLD;
            HOLD:    if (div_tick) state_d = GAP;
            GAP:     if (gap_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    always_ff @(posedge sysClk_i) begin
        if (reset_i) begin
            cnt       <= '0;
            edge_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            miso_meta <= 1'b0;
            miso_s    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            done_q    <= 1'b0;
            rx_byte_q <= '0;
        end else begin
            miso_meta <= bus.miso_i;
            miso_s    <= miso_meta;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.start_i) begin
                        tx_sr    <= bus.byte_to_send_i[6:0];
                        mosi_q   <= bus.byte_to_send_i[7];
                        ss_n_q   <= 1'b0;
                        rx_sr    <= '0;
                        edge_cnt <= '0;
                    end
                end
                SETUP: begin
                    cnt <= div_tick ? '0 : cnt + 8'd1;
                end
                SHIFT: begin
                    if (div_tick) begin
                        cnt      <= '0;
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (!sclk_q) begin
                            rx_sr <= {rx_sr[6:0], miso_s};
                        end else begin
                            tx_sr  <= {tx_sr[5:0], 1'b0};
                            mosi_q <= (edge_cnt == 4'd15) ? 1'b0 : tx_sr[6];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_tick) begin
                        cnt       <= '0;
                        ss_n_q    <= 1'b1;
                        rx_byte_q <= rx_sr;
                        done_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    cnt <= gap_tick ? '0 : cnt + 8'd1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign bus.ready_o         = ready;
    assign bus.done_o          = done_q;
    assign bus.byte_received_o = rx_byte_q;
    assign bus.sclk_o          = sclk_q;
    assign bus.mosi_o          = mosi_q;
    assign bus.ss_o_n          = ss_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, bench-side slave, back-to-back,
// busy start, mid-transfer reset and SClk phase timing at CLK_DIV=6.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    spi_master_if if4 ();
    spi_master_if if6 ();

    logic       loop_sel = 1'b1;
    logic [7:0] slv_byte = 8'h3C;
    logic [7:0] slv_tx = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    logic       slv_ss_p = 1'b1;
    logic       slv_sc_p = 1'b0;

    assign if4.miso_i = loop_sel ? if4.mosi_o : slv_tx[7];
    assign if6.miso_i = if6.mosi_o;

    spi_master #(.CLK_DIV(4), .GAP_CYCLES(4)) dut4 (
        .sysClk_i (clk),
        .reset_i  (rst),
        .bus      (if4.master)
    );

    spi_master #(.CLK_DIV(6), .GAP_CYCLES(4)) dut6 (
        .sysClk_i (clk),
        .reset_i  (rst),
        .bus      (if6.master)
    );

    always #5 clk = ~clk;

    // Mode 0 slave sampled on the system clock, one cycle behind the pins.
    always @(posedge clk) begin
        slv_ss_p <= if4.ss_o_n;
        slv_sc_p <= if4.sclk_o;
        if (slv_ss_p && !if4.ss_o_n) begin
            slv_tx <= slv_byte;
            slv_rx <= 8'h00;
        end else if (!if4.ss_o_n) begin
            if (!slv_sc_p && if4.sclk_o) slv_rx <= {slv_rx[6:0], if4.mosi_o};
            if (slv_sc_p && !if4.sclk_o) slv_tx <= {slv_tx[6:0], 1'b0};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer4(input logic [7:0] tx, input int poke, output int ss_low,
                         output int done_cyc, output int ndone, output logic [7:0] bits,
                         output int overlap);
        logic prev;
        if4.byte_to_send_i = tx;
        if4.start_i = 1'b1;
        step();
        if4.start_i = 1'b0;
        ss_low = 0; done_cyc = 0; ndone = 0; bits = 8'h00; overlap = 0; prev = 1'b0;
        for (int c = 1; c <= 85; c++) begin
            if (!if4.ss_o_n) ss_low++;
            if (if4.sclk_o && !prev) bits = {bits[6:0], if4.mosi_o};
            prev = if4.sclk_o;
            if (if4.done_o) begin
                ndone++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (if4.done_o && if4.ready_o) overlap++;
            if (c == poke) begin
                if4.start_i = 1'b1;
                if4.byte_to_send_i = 8'h00;
            end else begin
                if4.start_i = 1'b0;
            end
            step();
        end
    endtask

    int          ss_low, done_cyc, ndone, overlap, edges;
    int          acc0, acc1, gap_hi, rises, falls, bad, viol, run;
    logic [7:0]  bits, rx1, rx2;
    logic        p;

    initial begin
        if4.start_i = 1'b0; if4.byte_to_send_i = 8'h00;
        if6.start_i = 1'b0; if6.byte_to_send_i = 8'h00;
        rst = 1'b1;
        repeat (3) step();
        check("rst_ss", 32'(if4.ss_o_n), 32'd1);
        check("rst_sclk", 32'(if4.sclk_o), 32'd0);
        check("rst_mosi", 32'(if4.mosi_o), 32'd0);
        check("rst_ready", 32'(if4.ready_o), 32'd1);
        check("rst_done", 32'(if4.done_o), 32'd0);
        check("rst_rx", 32'(if4.byte_received_o), 32'h00);
        check("rst6_ss", 32'(if6.ss_o_n), 32'd1);
        rst = 1'b0;
        step();

        // Loopback 8'hA5
        loop_sel = 1'b1;
        if4.byte_to_send_i = 8'hA5;
        if4.start_i = 1'b1;
        step();
        if4.start_i = 1'b0;
        check("acc_ss", 32'(if4.ss_o_n), 32'd0);
        check("acc_ready", 32'(if4.ready_o), 32'd0);
        check("acc_mosi", 32'(if4.mosi_o), 32'd1);
        repeat (100) step();
        check("lb_ready_back", 32'(if4.ready_o), 32'd1);
        xfer4(8'hA5, 0, ss_low, done_cyc, ndone, bits, overlap);
        check("lb_ss_low", 32'(ss_low), 32'd72);
        check("lb_done_cyc", 32'(done_cyc), 32'd73);
        check("lb_ndone", 32'(ndone), 32'd1);
        check("lb_mosi_bits", 32'(bits), 32'hA5);
        check("lb_rx", 32'(if4.byte_received_o), 32'hA5);
        check("lb_overlap", 32'(overlap), 32'd0);

        // start pulsed while busy at cycle 10
        xfer4(8'h5A, 10, ss_low, done_cyc, ndone, bits, overlap);
        check("busy_ndone", 32'(ndone), 32'd1);
        check("busy_bits", 32'(bits), 32'h5A);
        check("busy_rx", 32'(if4.byte_received_o), 32'h5A);
        check("busy_ss_low", 32'(ss_low), 32'd72);

        // Bench-side slave returns 8'h3C
        loop_sel = 1'b0;
        xfer4(8'hC3, 0, ss_low, done_cyc, ndone, bits, overlap);
        check("slv_master_rx", 32'(if4.byte_received_o), 32'h3C);
        check("slv_slave_rx", 32'(slv_rx), 32'hC3);
        check("slv_ndone", 32'(ndone), 32'd1);
        loop_sel = 1'b1;

        // Reset at SHIFT edge 5
        if4.byte_to_send_i = 8'hA5;
        if4.start_i = 1'b1;
        step();
        if4.start_i = 1'b0;
        edges = 0; p = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (if4.sclk_o != p) edges++;
            p = if4.sclk_o;
            if (edges == 5) break;
        end
        check("mid_edges", 32'(edges), 32'd5);
        rst = 1'b1;
        step();
        check("mid_ss", 32'(if4.ss_o_n), 32'd1);
        check("mid_sclk", 32'(if4.sclk_o), 32'd0);
        check("mid_ready", 32'(if4.ready_o), 32'd1);
        check("mid_done", 32'(if4.done_o), 32'd0);
        check("mid_rx", 32'(if4.byte_received_o), 32'h00);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (if4.done_o) ndone++;
        end
        check("mid_no_done", 32'(ndone), 32'd0);

        // Back-to-back with start held high
        if4.byte_to_send_i = 8'h01;
        if4.start_i = 1'b1;
        acc0 = -1; acc1 = -1; ndone = 0; gap_hi = 0; rx1 = 8'h00; rx2 = 8'h00;
        for (int c = 0; c < 170; c++) begin
            if (if4.done_o) begin
                ndone++;
                if (ndone == 1) rx1 = if4.byte_received_o;
                else if (ndone == 2) rx2 = if4.byte_received_o;
            end
            if (ndone >= 1 && acc1 < 0 && if4.ss_o_n) gap_hi++;
            if (if4.ready_o && if4.start_i) begin
                if (acc0 < 0) acc0 = c;
                else if (acc1 < 0) acc1 = c;
            end
            if (acc0 >= 0 && c > acc0) if4.byte_to_send_i = 8'hFF;
            if (acc1 >= 0 && c > acc1) if4.start_i = 1'b0;
            step();
        end
        if4.start_i = 1'b0;
        check("b2b_acc0", 32'(acc0), 32'd0);
        check("b2b_start_to_start", 32'(acc1 - acc0), 32'd77);
        check("b2b_ndone", 32'(ndone), 32'd2);
        check("b2b_rx1", 32'(rx1), 32'h01);
        check("b2b_rx2", 32'(rx2), 32'hFF);
        check("b2b_ss_high", 32'(gap_hi), 32'd5);

        // SClk phase timing at CLK_DIV=6
        if6.byte_to_send_i = 8'h96;
        if6.start_i = 1'b1;
        step();
        if6.start_i = 1'b0;
        rises = 0; falls = 0; bad = 0; viol = 0; run = 0; p = 1'b0; ss_low = 0;
        for (int c = 1; c <= 130; c++) begin
            if (!if6.ss_o_n) ss_low++;
            if (if6.ss_o_n && if6.sclk_o) viol++;
            if (if6.sclk_o != p) begin
                if (p) begin
                    falls++;
                    if (run != 6) bad++;
                end else begin
                    rises++;
                    if (rises > 1 && run != 6) bad++;
                end
                run = 1;
            end else begin
                run++;
            end
            p = if6.sclk_o;
            step();
        end
        check("d6_rises", 32'(rises), 32'd8);
        check("d6_falls", 32'(falls), 32'd8);
        check("d6_phase_len", 32'(bad), 32'd0);
        check("d6_sclk_idle", 32'(viol), 32'd0);
        check("d6_ss_low", 32'(ss_low), 32'd108);
        check("d6_rx", 32'(if6.byte_received_o), 32'h96);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
